instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  IF stage of the MUSA core; consumes the next-address/redirect from EX and returns instructions to ID.
//  Holds the PC and issues word-addressed requests to instruction memory, at most one outstanding.
//  Buffers returned instructions in a small FIFO and hands them to ID on a valid/ready handshake.
//  A taken branch or jump redirects the PC, flushes the buffer and discards any in-flight fetch.
// PARAMETERS
//  ADDR_W      32  PC / imem address width, word-addressed (+1 per instruction)
//  DATA_W      32  instruction width
//  DEPTH       2   instruction buffer entries (>=1)
//  RESET_ADDR  0   PC value loaded by reset
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       reset, synchronous, active-high
//  redirect_valid  in   1       1-cycle pulse from EX: taken branch/jump
//  redirect_addr   in   ADDR_W  new PC, sampled when redirect_valid=1
//  imem_req        out  1       fetch request
//  imem_addr       out  ADDR_W  fetch address, stable while imem_req=1 and not acked
//  imem_ack        in   1       response this cycle; may be same cycle as imem_req
//  imem_rdata      in   DATA_W  instruction, valid only when imem_ack=1
//  if_valid        out  1       buffer head valid toward ID
//  if_instr        out  DATA_W  head instruction
//  if_pc           out  ADDR_W  address of head instruction
//  id_ready        in   1       ID accepts head; pop when if_valid & id_ready
// BEHAVIOUR
//  Reset (sync, checked at clk edge): pc=RESET_ADDR, FIFO empty, state=REQ, imem_req=0 in the reset
//   cycle, if_valid=0, if_instr=0, if_pc=0. All outputs driven low while reset=1.
//  FSM states: REQ (may issue), DROP (outstanding fetch to be discarded).
//  REQ: imem_req=1, imem_addr=pc when occupancy<DEPTH OR a pop occurs this cycle; else imem_req=0.
//   Once raised, imem_req holds with the same imem_addr until imem_ack (no withdrawal).
//   imem_ack: push {pc, imem_rdata}, pc<=pc+1 (wraps mod 2^ADDR_W), stay REQ.
//   Throughput 1 instr/cycle with zero-wait memory and id_ready=1.
//  Latency: imem_ack at edge N -> if_valid=1 with that instr after edge N (cycle N+1).
//  Redirect (highest priority, any state): FIFO flushed, pc<=redirect_addr at the same edge.
//   - request outstanding and imem_ack=0: state->DROP; imem_req stays high on the old address.
//   - imem_ack=1 same cycle: response discarded, no push, state REQ.
//   - pop same cycle: handshake counts as completed; flush still applies; ID squashes it.
//  DROP: imem_req=1 at old address; on imem_ack discard data, no push, pc unchanged -> REQ.
//   A second redirect in DROP only updates pc; stay DROP.
//  Simultaneous push+pop: occupancy unchanged; push allowed into a full FIFO only if popping.
//  FIFO full, no pop: no new request issued; outstanding request still completes (space was
//   reserved at issue: occupancy+outstanding<=DEPTH always).
//  Reset mid-fetch: outstanding response after reset is not tracked; imem ignores reset-cycle req.
// STRUCTURE
//  musa_fetch_pkg: fetch_state_t enum {REQ, DROP}; RESET_ADDR default; fetch entry struct {pc, instr}.
//  Sub-module fetch_fifo: DEPTH-entry sync FIFO, push/pop/flush, full/empty, flush beats push.
//  Top: PC register, FSM, request gating, occupancy+outstanding accounting.
// TESTING
//  1 Reset, imem_ack=imem_req, id_ready=1 -> imem_addr 0,1,2,3 on consecutive cycles; if_pc 0,1,2 from cycle 2.
//  2 id_ready=0, zero-wait mem -> exactly DEPTH entries fetched (pc 0,1), then imem_req=0; release -> pc 2 fetched.
//  3 Mem ack delay 3, redirect_addr=0x40 while waiting -> DROP; old data never on if_instr; next imem_addr=0x40.
//  4 Redirect 0x80 in same cycle as imem_ack -> no push, FIFO empty next cycle, next imem_addr=0x80.
//  5 pc=0xFFFFFFFF fetched -> next imem_addr=0x0, if_pc sequence 0xFFFFFFFF then 0x0.
//  6 Assert reset during DROP with buffer full -> next cycle if_valid=0, first imem_addr=RESET_ADDR.

Source files
------------

// File: rtl/musa_fetch_pkg.sv
// Shared types and defaults for the MUSA instruction fetch stage.
package musa_fetch_pkg;

  typedef enum logic [0:0] {
    REQ  = 1'b0,
    DROP = 1'b1
  } fetch_state_t;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_ADDR = '0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous instruction buffer; flush wins over a same-cycle push,
// and a push into a full buffer is accepted only alongside a pop.
module fetch_fifo
  import musa_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign do_pop    = pop && !empty && !flush;
  assign do_push   = push && !flush && (!full || do_pop);
  assign head_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (do_push && !do_pop)      count_reg <= count_reg + CNT_W'(1);
      else if (!do_push && do_pop) count_reg <= count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// MUSA IF stage: PC register, single-outstanding imem request FSM and
// the instruction buffer feeding ID.
module instr_fetch_unit
  import musa_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter int unsigned       DATA_W     = DEF_DATA_W,
  parameter int unsigned       DEPTH      = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DEF_RESET_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready
);

  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              out_reg, out_next;
  logic              req, push, flush, pop, head_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ENT_W-1:0]  head_data;
  logic              fifo_empty, fifo_full;

  // An outstanding request keeps its latched address even after a redirect moves pc.
  assign fetch_addr = out_reg ? addr_reg : pc_reg;

  assign head_valid = !reset && !fifo_empty;
  assign pop        = head_valid && id_ready;
  assign if_valid   = head_valid;
  assign if_pc      = head_valid ? head_data[ENT_W-1:DATA_W] : '0;
  assign if_instr   = head_valid ? head_data[DATA_W-1:0] : '0;
  assign imem_req   = req;
  assign imem_addr  = reset ? '0 : fetch_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= REQ;
      pc_reg    <= RESET_ADDR;
      addr_reg  <= '0;
      out_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      addr_reg  <= addr_next;
      out_reg   <= out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    addr_next  = addr_reg;
    out_next   = out_reg;
    req        = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;

    // A new request needs a free slot now or one freed by this cycle's pop.
    if (!reset) begin
      if (state_reg == DROP || out_reg) req = 1'b1;
      else                              req = !fifo_full || pop;
    end

    case (state_reg)
      REQ: begin
        if (req && imem_ack) begin
          push     = 1'b1;
          pc_next  = pc_reg + ADDR_W'(1);
          out_next = 1'b0;
        end else if (req) begin
          out_next  = 1'b1;
          addr_next = fetch_addr;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_next = REQ;
          out_next   = 1'b0;
        end
      end
      default: state_next = REQ;
    endcase

    if (redirect_valid) begin
      flush   = 1'b1;
      push    = 1'b0;
      pc_next = redirect_addr;
      if (state_reg == REQ && req && !imem_ack) state_next = DROP;
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data ({fetch_addr, imem_rdata}),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized checks of instr_fetch_unit against a queue-based
// transaction model and a bench-side instruction memory.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RST_ADDR = 32'h0;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, imem_req, imem_ack, if_valid, id_ready;
  logic [31:0] redirect_addr, imem_addr, imem_rdata, if_instr, if_pc;

  instr_fetch_unit #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .DEPTH      (DEPTH),
    .RESET_ADDR (RST_ADDR)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int          errors = 0;
  int          checks = 0;
  ent_t        q[$];
  logic [31:0] fetch_pc, pend_addr, id_expect;
  bit          pending, dropping, mem_busy;
  int          mem_wait;
  int          mem_delay;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, play memory, check against the model, advance the model.
  task automatic cycle(input bit rst, input bit rdy, input bit redir, input logic [31:0] raddr);
    bit pop;
    bit ack_hit;
    @(negedge clk);
    reset          = rst;
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_addr  = raddr;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    #1;
    if (!rst && imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_wait = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
      end
      if (mem_wait == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = memfn(imem_addr);
        mem_busy   = 1'b0;
      end else begin
        mem_wait--;
      end
    end
    #1;
    if (rst) begin
      check_b("rst_imem_req", imem_req, 1'b0);
      check_w("rst_imem_addr", imem_addr, 32'h0);
      check_b("rst_if_valid", if_valid, 1'b0);
      check_w("rst_if_pc", if_pc, 32'h0);
      check_w("rst_if_instr", if_instr, 32'h0);
      q.delete();
      fetch_pc  = RST_ADDR;
      id_expect = RST_ADDR;
      pending   = 1'b0;
      dropping  = 1'b0;
      mem_busy  = 1'b0;
    end else begin
      pop = (q.size() != 0) && rdy;
      check_b("if_valid", if_valid, q.size() != 0);
      if (q.size() != 0) begin
        check_w("if_pc", if_pc, q[0].pc);
        check_w("if_instr", if_instr, q[0].instr);
      end
      if (pending) begin
        check_b("req_hold", imem_req, 1'b1);
        check_w("addr_hold", imem_addr, pend_addr);
      end else begin
        check_b("req_gate", imem_req, (q.size() < DEPTH) || pop);
        if (imem_req) check_w("req_addr", imem_addr, fetch_pc);
      end
      if (pop) begin
        check_w("id_pc", if_pc, id_expect);
        check_w("id_instr", if_instr, memfn(id_expect));
        $display("xfer pc=%08h instr=%08h", if_pc, if_instr);
        id_expect++;
      end
      ack_hit = imem_req && imem_ack;
      if (redir) begin
        q.delete();
        fetch_pc  = raddr;
        id_expect = raddr;
        if (imem_req && !imem_ack) begin
          pending   = 1'b1;
          dropping  = 1'b1;
          pend_addr = imem_addr;
        end else begin
          pending  = 1'b0;
          dropping = 1'b0;
        end
      end else begin
        if (pop) void'(q.pop_front());
        if (ack_hit) begin
          if (!dropping) begin
            q.push_back('{fetch_pc, memfn(fetch_pc)});
            fetch_pc++;
          end
          dropping = 1'b0;
          pending  = 1'b0;
        end else if (imem_req) begin
          pending   = 1'b1;
          pend_addr = imem_addr;
        end
      end
    end
  endtask

  initial begin
    bit found;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    id_ready       = 1'b0;
    mem_busy       = 1'b0;
    mem_wait       = 0;
    mem_delay      = 0;

    // Zero-wait memory, ID always ready: one fetch per cycle.
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0);
      check_b("t1_req", imem_req, 1'b1);
      check_w("t1_addr", imem_addr, 32'(i));
      if (i >= 1) begin
        check_b("t1_valid", if_valid, 1'b1);
        check_w("t1_if_pc", if_pc, 32'(i - 1));
      end
    end

    // ID stalled: exactly DEPTH entries, then requests stop until a pop.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_w("t2_addr0", imem_addr, 32'h0);
    cycle(0, 0, 0, 0);
    check_w("t2_addr1", imem_addr, 32'h1);
    cycle(0, 0, 0, 0);
    check_b("t2_full_noreq", imem_req, 1'b0);
    cycle(0, 0, 0, 0);
    check_b("t2_full_noreq2", imem_req, 1'b0);
    check_w("t2_head", if_pc, 32'h0);
    cycle(0, 1, 0, 0);
    check_b("t2_release_req", imem_req, 1'b1);
    check_w("t2_release_addr", imem_addr, 32'h2);

    // Redirect while a slow fetch is outstanding: old response is dropped.
    mem_delay = 3;
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 32'h40);
    check_w("t3_hold_addr", imem_addr, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      cycle(0, 1, 0, 0);
      check_b("t3_no_old_data", if_valid, 1'b0);
      if (imem_req && imem_addr == 32'h40) found = 1'b1;
    end
    check_b("t3_new_addr_seen", found, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      cycle(0, 1, 0, 0);
      if (if_valid) found = 1'b1;
    end
    check_b("t3_first_valid", found, 1'b1);
    check_w("t3_first_pc", if_pc, 32'h40);

    // Redirect in the same cycle as an ack: nothing pushed.
    mem_delay = 0;
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 32'h80);
    check_w("t4_acked_addr", imem_addr, 32'h1);
    cycle(0, 0, 0, 0);
    check_b("t4_empty", if_valid, 1'b0);
    check_w("t4_next_addr", imem_addr, 32'h80);
    cycle(0, 1, 0, 0);
    check_w("t4_head_pc", if_pc, 32'h80);

    // PC wraparound.
    cycle(1, 1, 0, 0);
    cycle(0, 1, 1, 32'hFFFFFFFF);
    cycle(0, 1, 0, 0);
    check_w("t5_addr_top", imem_addr, 32'hFFFFFFFF);
    cycle(0, 1, 0, 0);
    check_w("t5_addr_wrap", imem_addr, 32'h0);
    check_w("t5_pc_top", if_pc, 32'hFFFFFFFF);
    cycle(0, 1, 0, 0);
    check_w("t5_pc_wrap", if_pc, 32'h0);

    // Reset with a full buffer.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_b("t6_full_valid", if_valid, 1'b1);
    check_b("t6_full_noreq", imem_req, 1'b0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_b("t6_valid_after_rst", if_valid, 1'b0);
    check_w("t6_addr_after_rst", imem_addr, RST_ADDR);

    // Reset while dropping an outstanding fetch.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    mem_delay = 3;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h20);
    cycle(0, 0, 0, 0);
    check_b("t6_drop_req", imem_req, 1'b1);
    check_w("t6_drop_addr", imem_addr, 32'h1);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_b("t6_valid_after_drop_rst", if_valid, 1'b0);
    check_b("t6_req_after_drop_rst", imem_req, 1'b1);
    check_w("t6_addr_after_drop_rst", imem_addr, RST_ADDR);

    // Randomized traffic against the model.
    mem_delay = -1;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      bit          rdy, redir, rst;
      logic [31:0] raddr;
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      raddr = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 3)))
                                          : 32'($urandom);
      cycle(rst, rdy, redir, raddr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
